// File: rtl/stream_rev_pkg.sv
// Shared types for the streaming reorder stage: per-beat permutation modes and skid-buffer occupancy states.
// No logic; imported by the permutation core, the pipeline top and anything that decodes modes.
// Backpressure: not applicable.
package stream_rev_pkg;

    typedef enum logic [1:0] {
        PASS       = 2'd0,
        BITREV     = 2'd1,
        SLICEREV   = 2'd2,
        INSLICEREV = 2'd3
    } rev_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stream_rev_perm.sv
// Combinational word permutation: pass, full bit-reverse, slice-reverse or bit-reverse inside each slice.
// Latency: zero cycles, purely combinational.
// Backpressure: none, the caller owns all flow control.
module stream_rev_perm
    import stream_rev_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] perm
);

    localparam int NSLICE = WIDTH / SLICE;

    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("stream_rev_perm: WIDTH=%0d must be >= 2 and a multiple of SLICE=%0d", WIDTH, SLICE);
    end

    logic [WIDTH-1:0] full_rev;
    logic [WIDTH-1:0] slice_rev;
    logic [WIDTH-1:0] inslice_rev;

    assign full_rev  = {<<{data}};
    assign slice_rev = {<<SLICE{data}};

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        assign inslice_rev[k*SLICE +: SLICE] = {<<{data[k*SLICE +: SLICE]}};
    end

    // An unknown mode propagates X to the data so a bad driver is visible downstream.
    always_comb begin
        perm = 'x;
        case (mode)
            PASS:       perm = data;
            BITREV:     perm = full_rev;
            SLICEREV:   perm = slice_rev;
            INSLICEREV: perm = inslice_rev;
            default:    perm = 'x;
        endcase
    end

endmodule

// File: rtl/stream_rev_pipe.sv
// Registered reorder stage with a 2-entry skid buffer; optional out_parity under STREAM_REV_PARITY_EN.
// Latency: one cycle from accept to out_valid when empty; one beat per cycle sustained.
// Backpressure: registered in_ready drops only when both entries are held; output holds while stalled.
module stream_rev_pipe
    import stream_rev_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef STREAM_REV_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [WIDTH-1:0] perm_dat;
    logic [WIDTH-1:0] skid_dat;
    logic             acc;
    logic             xfer;
    logic             load_head;
    logic             head_from_skid;
    logic             load_skid;

    stream_rev_perm #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) u_perm (
        .mode (in_mode),
        .data (in_data),
        .perm (perm_dat)
    );

    assign acc       = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign out_valid = (state_q != EMPTY);

    // out_data is the head entry; skid_dat only holds the younger beat while FULL.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d   = HALF;
                    load_head = 1'b1;
                end
            end
            HALF: begin
                if (acc && xfer) begin
                    load_head = 1'b1;
                end else if (acc) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d        = HALF;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b0;
            out_data <= '0;
            skid_dat <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != FULL);
            if (load_head) begin
                out_data <= perm_dat;
            end else if (head_from_skid) begin
                out_data <= skid_dat;
            end
            if (load_skid) begin
                skid_dat <= perm_dat;
            end
        end
    end

`ifdef STREAM_REV_PARITY_EN
    logic skid_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
            skid_par   <= 1'b0;
        end else begin
            if (load_head) begin
                out_parity <= ^perm_dat;
            end else if (head_from_skid) begin
                out_parity <= skid_par;
            end
            if (load_skid) begin
                skid_par <= ^perm_dat;
            end
        end
    end
`endif

endmodule
